// File: rtl/deserializer.sv
// Serial-to-parallel receiver: collects MSB-first bursts qualified by a valid
// strobe and emits one parallel word plus its valid-bit count per burst.
module deserializer #(
    parameter int DATA_BUS_WIDTH = 16,
    parameter int DATA_MOD_WIDTH = $clog2(DATA_BUS_WIDTH)
) (
    input  logic                      clk_i,
    input  logic                      srst_i,
    input  logic                      ser_data_i,
    input  logic                      ser_data_val_i,
    output logic [DATA_BUS_WIDTH-1:0] data_o,
    output logic [DATA_MOD_WIDTH-1:0] data_mod_o,
    output logic                      data_val_o,
    output logic                      runt_o,
    output logic                      busy_o
);

    localparam int CNT_W = $clog2(DATA_BUS_WIDTH + 1);

    typedef enum logic {IDLE, RECV} state_t;

    state_t                      state, state_nxt;
    logic [CNT_W-1:0]            cnt, cnt_nxt;
    logic [DATA_BUS_WIDTH-1:0]   shift_buf, shift_buf_nxt;
    logic [DATA_BUS_WIDTH-1:0]   word_nxt;
    logic [DATA_MOD_WIDTH-1:0]   mod_nxt;
    logic                        emit_nxt;
    logic                        runt_nxt;

    // The k-th bit of a word lands at position W-1-k.
    function automatic logic [DATA_BUS_WIDTH-1:0] insert_bit(
        input logic [DATA_BUS_WIDTH-1:0] word_in,
        input logic [CNT_W-1:0]          pos,
        input logic                      bit_in
    );
        logic [DATA_BUS_WIDTH-1:0] r;
        r = word_in;
        for (int i = 0; i < DATA_BUS_WIDTH; i++) begin
            if (CNT_W'(DATA_BUS_WIDTH - 1 - i) == pos)
                r[i] = bit_in;
        end
        return r;
    endfunction

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state     <= IDLE;
            cnt       <= '0;
            shift_buf <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            shift_buf <= shift_buf_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        shift_buf_nxt = shift_buf;
        word_nxt      = shift_buf;
        mod_nxt       = '0;
        emit_nxt      = 1'b0;
        runt_nxt      = 1'b0;
        case (state)
            IDLE: begin
                if (ser_data_val_i) begin
                    shift_buf_nxt = {ser_data_i, {(DATA_BUS_WIDTH-1){1'b0}}};
                    cnt_nxt       = CNT_W'(1);
                    state_nxt     = RECV;
                end
            end
            RECV: begin
                if (ser_data_val_i) begin
                    shift_buf_nxt = insert_bit(shift_buf, cnt, ser_data_i);
                    if (cnt == CNT_W'(DATA_BUS_WIDTH - 1)) begin
                        emit_nxt  = 1'b1;
                        word_nxt  = shift_buf_nxt;
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end else begin
                    // Burst ended early: short words are emitted, 1-2 bit bursts are dropped.
                    if (cnt >= CNT_W'(3)) begin
                        emit_nxt = 1'b1;
                        mod_nxt  = cnt[DATA_MOD_WIDTH-1:0];
                    end else begin
                        runt_nxt = 1'b1;
                    end
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            data_o     <= '0;
            data_mod_o <= '0;
            data_val_o <= 1'b0;
            runt_o     <= 1'b0;
        end else begin
            data_val_o <= emit_nxt;
            runt_o     <= runt_nxt;
            if (emit_nxt) begin
                data_o     <= word_nxt;
                data_mod_o <= mod_nxt;
            end
        end
    end

    always_comb begin
        busy_o = (state == RECV);
    end

endmodule

// File: tb/tb_deserializer.sv
// Directed and loopback-style bench for the deserializer.
module tb_deserializer;

    localparam int W  = 16;
    localparam int MW = 4;

    logic          clk_i = 1'b0;
    logic          srst_i;
    logic          ser_data_i;
    logic          ser_data_val_i;
    logic [W-1:0]  data_o;
    logic [MW-1:0] data_mod_o;
    logic          data_val_o;
    logic          runt_o;
    logic          busy_o;

    int n_checks = 0;
    int n_errors = 0;
    int val_pulses = 0;
    int runt_pulses = 0;
    int overlap_cnt = 0;

    deserializer #(.DATA_BUS_WIDTH(W), .DATA_MOD_WIDTH(MW)) dut (
        .clk_i          (clk_i),
        .srst_i         (srst_i),
        .ser_data_i     (ser_data_i),
        .ser_data_val_i (ser_data_val_i),
        .data_o         (data_o),
        .data_mod_o     (data_mod_o),
        .data_val_o     (data_val_o),
        .runt_o         (runt_o),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Independent pulse bookkeeping, sampled mid-cycle.
    always @(negedge clk_i) begin
        if (data_val_o === 1'b1) val_pulses++;
        if (runt_o === 1'b1) runt_pulses++;
        if (data_val_o === 1'b1 && runt_o === 1'b1) overlap_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic v, input logic b);
        ser_data_val_i = v;
        ser_data_i     = b;
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_word(input logic [W-1:0] w, input int n);
        for (int k = 0; k < n; k++) send_bit(1'b1, w[W-1-k]);
    endtask

    logic [W-1:0]  word;
    logic [W-1:0]  exp_word;
    logic [MW-1:0] exp_mod;
    int            nbits;

    initial begin
        srst_i = 1'b1;
        ser_data_i = 1'b0;
        ser_data_val_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_data", data_o, 0);
        check("rst_mod", data_mod_o, 0);
        check("rst_val", data_val_o, 0);
        check("rst_runt", runt_o, 0);
        check("rst_busy", busy_o, 0);
        srst_i = 1'b0;
        send_bit(1'b0, 1'b0);

        // Full word
        word = 16'hA5C3;
        for (int k = 0; k < W; k++) begin
            send_bit(1'b1, word[W-1-k]);
            if (k == 0)  check("t1_busy_b1", busy_o, 1);
            if (k == 14) check("t1_busy_b15", busy_o, 1);
            if (k == 14) check("t1_noval_b15", data_val_o, 0);
        end
        check("t1_val", data_val_o, 1);
        check("t1_data", data_o, 16'hA5C3);
        check("t1_mod", data_mod_o, 0);
        check("t1_busy_end", busy_o, 0);
        send_bit(1'b0, 1'b0);
        check("t1_val_once", data_val_o, 0);
        check("t1_hold", data_o, 16'hA5C3);

        // Partial word 10110
        send_word(16'hB000, 5);
        send_bit(1'b0, 1'b0);
        check("t2_val", data_val_o, 1);
        check("t2_data", data_o, 16'hB000);
        check("t2_mod", data_mod_o, 5);
        send_bit(1'b0, 1'b0);
        check("t2_val_once", data_val_o, 0);

        // Runt burst 11
        send_word(16'hC000, 2);
        send_bit(1'b0, 1'b0);
        check("t3_runt", runt_o, 1);
        check("t3_noval", data_val_o, 0);
        check("t3_hold", data_o, 16'hB000);
        check("t3_hold_mod", data_mod_o, 5);
        send_bit(1'b0, 1'b0);
        check("t3_runt_once", runt_o, 0);

        // Back-to-back words, no gap
        send_word(16'h1234, W);
        check("t4_val1", data_val_o, 1);
        check("t4_data1", data_o, 16'h1234);
        send_bit(1'b1, 1'b1);
        check("t4_busy_b17", busy_o, 1);
        check("t4_val_gap", data_val_o, 0);
        for (int k = 1; k < W; k++) send_bit(1'b1, 1'b1);
        check("t4_val2", data_val_o, 1);
        check("t4_data2", data_o, 16'hFFFF);
        check("t4_mod2", data_mod_o, 0);
        send_bit(1'b0, 1'b0);
        check("t4_idle", data_val_o, 0);

        // Reset mid-burst, then 101
        send_word(16'hFE00, 7);
        srst_i = 1'b1;
        send_bit(1'b0, 1'b0);
        srst_i = 1'b0;
        check("t5_rst_val", data_val_o, 0);
        check("t5_rst_runt", runt_o, 0);
        check("t5_rst_busy", busy_o, 0);
        check("t5_rst_data", data_o, 0);
        send_bit(1'b0, 1'b0);
        check("t5_quiet_val", data_val_o, 0);
        check("t5_quiet_runt", runt_o, 0);
        send_word(16'hA000, 3);
        send_bit(1'b0, 1'b0);
        check("t5_val", data_val_o, 1);
        check("t5_data", data_o, 16'hA000);
        check("t5_mod", data_mod_o, 3);

        // Randomised serializer-style traffic
        for (int n = 0; n < 1000; n++) begin
            int r;
            word = 16'($urandom);
            r = $urandom_range(0, 13);
            exp_mod = (r == 0) ? 4'd0 : MW'(r + 2);
            nbits = (r == 0) ? W : r + 2;
            exp_word = word;
            for (int i = 0; i < W - nbits; i++) exp_word[i] = 1'b0;
            send_word(word, nbits);
            if (nbits != W) send_bit(1'b0, 1'b0);
            check("t6_val", data_val_o, 1);
            check("t6_data", data_o, exp_word);
            check("t6_mod", data_mod_o, exp_mod);
            if (nbits == W || $urandom_range(0, 1) == 1) send_bit(1'b0, 1'b0);
        end
        send_bit(1'b0, 1'b0);
        @(negedge clk_i);
        check("total_val_pulses", val_pulses, 1005);
        check("total_runt_pulses", runt_pulses, 1);
        check("val_runt_overlap", overlap_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
